mem_arbiter_2p: RTL and testbench

Two-requester arbiter and sequencer for the 32-byte banked memory (four 8-byte chips, 5-bit address, 8-bit data, separate read_en/write_en). Requesters A and B each issue single-byte read or write transactions with a req/ack handshake. The block grants one requester at a time in round-robin order, drives the memory control signals and returns read data. It sits between the requester logic and the memory top level, and is the only driver of the memory's address, data and enable inputs.

---
 rtl/mem_arbiter_2p_pkg.sv | 17 +
 rtl/mem_arbiter_2p_rr_pick_2.sv | 22 ++
 rtl/mem_arbiter_2p.sv | 128 ++++++++++++
 tb/tb_mem_arbiter_2p.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_2p_pkg.sv
// Shared encodings and default widths for the two-port memory arbiter.
package mem_arbiter_2p_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_arbiter_2p_rr_pick_2.sv
// Combinational 2-way round-robin pick: sole requester wins, prio breaks ties.
// Zero latency; no backpressure (pure function of req and prio).
module mem_arbiter_2p_rr_pick_2
  import mem_arbiter_2p_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       valid,
  output logic       gnt
);

  always_comb begin
    valid = |req;
    gnt   = GNT_A;
    if (req == 2'b11) begin
      gnt = prio;
    end else if (req[1]) begin
      gnt = GNT_B;
    end
  end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Round-robin arbiter/sequencer for two single-byte requesters sharing the banked memory.
// Write ack 2 cycles after the IDLE grant cycle, read ack 2+RD_LAT; losers hold req until granted.
module mem_arbiter_2p
  import mem_arbiter_2p_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int CNT_W = 2;

  state_t            state;
  logic              prio;
  logic              gnt_id;
  logic              lat_we;
  logic [CNT_W-1:0]  wait_cnt;
  logic              pick_vld;
  logic              pick_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  mem_arbiter_2p_rr_pick_2 u_rr_pick_2 (
    .req   ({b_req, a_req}),
    .prio  (prio),
    .valid (pick_vld),
    .gnt   (pick_gnt)
  );

  assign sel_we    = (pick_gnt == GNT_B) ? b_we    : a_we;
  assign sel_addr  = (pick_gnt == GNT_B) ? b_addr  : a_addr;
  assign sel_wdata = (pick_gnt == GNT_B) ? b_wdata : a_wdata;

  // mem_address / mem_data_in double as the latched request, so they hold until the next grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      prio         <= GNT_A;
      gnt_id       <= GNT_A;
      lat_we       <= 1'b0;
      wait_cnt     <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      mem_address  <= '0;
      mem_data_in  <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      busy         <= 1'b0;
    end else begin
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_id      <= pick_gnt;
            lat_we      <= sel_we;
            mem_address <= sel_addr;
            if (sel_we) begin
              mem_data_in  <= sel_wdata;
              mem_write_en <= 1'b1;
            end else begin
              mem_read_en <= 1'b1;
            end
            busy  <= 1'b1;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_we) begin
            a_ack <= (gnt_id == GNT_A);
            b_ack <= (gnt_id == GNT_B);
            state <= RESP;
          end else begin
            wait_cnt <= CNT_W'(RD_LAT - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            if (gnt_id == GNT_A) begin
              a_rdata <= mem_data_out;
            end else begin
              b_rdata <= mem_data_out;
            end
            a_ack <= (gnt_id == GNT_A);
            b_ack <= (gnt_id == GNT_B);
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          prio  <= ~gnt_id;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Randomized scoreboard bench: a transaction-level model predicts grants, latencies and read data.
module tb_mem_arbiter_2p;

  localparam int RD_LAT = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [4:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_ack, b_ack, mem_read_en, mem_write_en, busy;
  logic [7:0] a_rdata, b_rdata, mem_data_in, mem_data_out;
  logic [4:0] mem_address;

  always #5 clock = ~clock;

  mem_arbiter_2p #(.RD_LAT(RD_LAT), .ADDR_W(5), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out), .busy(busy)
  );

  // Memory with RD_LAT read latency; garbage on the data pipe when not reading.
  logic [7:0] mem_arr [32];
  logic [7:0] rd_pipe [RD_LAT];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= 8'h00;
    end else if (mem_write_en) begin
      mem_arr[mem_address] <= mem_data_in;
    end
    rd_pipe[0] <= mem_read_en ? mem_arr[mem_address] : 8'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_out = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int passed = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
  endtask

  task automatic fail_now(string name);
    checks++;
    $display("FAIL %s cycle %0d: got timeout expected event", name, cyc);
  endtask

  typedef struct {
    bit         id;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         acc_cyc;
    int         ack_cyc;
  } txn_t;

  txn_t       q[$];
  txn_t       cur;
  bit         cur_vld = 1'b0;
  bit         prio = 1'b0;
  int         next_free = 0;
  int         gnt_cnt [2] = '{0, 0};
  logic [7:0] held [2] = '{8'h00, 8'h00};
  logic [7:0] mem_ref [32];

  // Monitor checks this cycle's outputs, then the model decides what the DUT grants at the next edge.
  always @(negedge clock) begin
    txn_t t;
    bit   exp_busy, acc;
    exp_busy = cur_vld && cyc >= cur.acc_cyc && cyc <= cur.ack_cyc;
    acc      = cur_vld && cyc == cur.acc_cyc;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("read_en", 32'(mem_read_en), 32'(acc && !cur.we));
    chk("write_en", 32'(mem_write_en), 32'(acc && cur.we));
    if (acc) begin
      chk("mem_address", 32'(mem_address), 32'(cur.addr));
      if (cur.we) chk("mem_data_in", 32'(mem_data_in), 32'(cur.wdata));
    end
    if (a_ack || b_ack) begin
      chk("ack_overlap", 32'(a_ack && b_ack), 32'(0));
      if (q.size() == 0) begin
        fail_now("spurious_ack");
      end else begin
        t = q.pop_front();
        chk("ack_id", 32'(b_ack), 32'(t.id));
        chk("ack_cycle", 32'(cyc), 32'(t.ack_cyc));
        if (!t.we) held[t.id] = t.rdata;
      end
    end else if (q.size() > 0 && cyc > q[0].ack_cyc) begin
      fail_now("missed_ack");
      void'(q.pop_front());
    end
    chk("a_rdata", 32'(a_rdata), 32'(held[0]));
    chk("b_rdata", 32'(b_rdata), 32'(held[1]));

    if (reset) begin
      q.delete();
      cur_vld   = 1'b0;
      prio      = 1'b0;
      next_free = cyc + 1;
      held[0]   = 8'h00;
      held[1]   = 8'h00;
      for (int i = 0; i < 32; i++) mem_ref[i] = 8'h00;
    end else if (cyc >= next_free && (a_req || b_req)) begin
      t.id      = (a_req && b_req) ? prio : b_req;
      t.we      = t.id ? b_we : a_we;
      t.addr    = t.id ? b_addr : a_addr;
      t.wdata   = t.id ? b_wdata : a_wdata;
      t.rdata   = mem_ref[t.addr];
      if (t.we) mem_ref[t.addr] = t.wdata;
      t.acc_cyc = cyc + 1;
      t.ack_cyc = cyc + 2 + (t.we ? 0 : RD_LAT);
      next_free = t.ack_cyc + 1;
      prio      = !t.id;
      q.push_back(t);
      cur     = t;
      cur_vld = 1'b1;
      gnt_cnt[t.id]++;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(bit id, bit req, bit we, logic [4:0] addr, logic [7:0] wd);
    if (id) begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
  endtask

  function automatic bit ack_of(bit id);
    return id ? b_ack : a_ack;
  endfunction

  task automatic do_txn(bit id, bit we, logic [4:0] addr, logic [7:0] wd, bit drop);
    int n;
    int gc;
    gc = gnt_cnt[id];
    drive(id, 1'b1, we, addr, wd);
    if (drop) begin
      n = 0;
      while (gnt_cnt[id] == gc && n < 60) begin step(1); n++; end
      if (gnt_cnt[id] == gc) fail_now("grant_timeout");
      // Scrambled inputs after the grant must not affect the transaction.
      drive(id, 1'b0, ~we, ~addr, ~wd);
    end
    n = 0;
    while (!ack_of(id) && n < 60) begin step(1); n++; end
    if (!ack_of(id)) fail_now("ack_timeout");
    if (id) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  logic [4:0] bnd [4] = '{5'h00, 5'h07, 5'h08, 5'h1F};

  initial begin
    int gc;
    int n;
    logic [7:0] wd;
    step(2);
    reset = 1'b0;
    step(5);

    do_txn(1'b0, 1'b1, 5'h13, 8'h5A, 1'b0);
    do_txn(1'b0, 1'b0, 5'h13, 8'h00, 1'b0);
    step(3);

    do_reset(2);
    fork
      do_txn(1'b0, 1'b1, 5'h00, 8'h11, 1'b0);
      do_txn(1'b1, 1'b1, 5'h08, 8'h22, 1'b0);
    join
    do_txn(1'b1, 1'b0, 5'h00, 8'h00, 1'b0);
    do_txn(1'b0, 1'b0, 5'h08, 8'h00, 1'b0);
    step(2);

    fork
      for (int i = 0; i < 4; i++) do_txn(1'b0, 1'($urandom), 5'($urandom), 8'($urandom), 1'b0);
      for (int j = 0; j < 4; j++) do_txn(1'b1, 1'($urandom), 5'($urandom), 8'($urandom), 1'b0);
    join
    step(2);

    // Leave prio on B, then reset in the middle of an A read.
    do_txn(1'b0, 1'b1, 5'h05, 8'hC3, 1'b0);
    step(1);
    gc = gnt_cnt[0];
    drive(1'b0, 1'b1, 1'b0, 5'h05, 8'h00);
    n = 0;
    while (gnt_cnt[0] == gc && n < 60) begin step(1); n++; end
    if (gnt_cnt[0] == gc) fail_now("reset_read_grant");
    step(1);
    reset = 1'b1;
    a_req = 1'b0;
    step(1);
    reset = 1'b0;
    step(2);
    fork
      do_txn(1'b0, 1'b1, 5'h10, 8'hA1, 1'b0);
      do_txn(1'b1, 1'b1, 5'h11, 8'hB2, 1'b0);
    join
    step(2);

    foreach (bnd[k]) begin
      wd = 8'($urandom);
      do_txn(1'b0, 1'b1, bnd[k], wd, 1'b1);
      step(1);
      do_txn(1'b0, 1'b0, bnd[k], 8'h00, 1'b1);
      step(1);
    end

    fork
      for (int i = 0; i < 30; i++) begin
        do_txn(1'b0, 1'($urandom), 5'($urandom), 8'($urandom), ($urandom_range(3) == 0));
        step($urandom_range(2));
      end
      for (int j = 0; j < 30; j++) begin
        do_txn(1'b1, 1'($urandom), 5'($urandom), 8'($urandom), ($urandom_range(3) == 0));
        step($urandom_range(2));
      end
    join

    step(10);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
